// File: rtl/mux_xbar_cfg.sv
// Channel-to-slot crossbar: N_IN W-bit channels onto N_OUT slots through a double-buffered routing table.
// Latency: in_valid -> out_valid in 2 cycles; a commit issued at cycle C takes effect at edge C+2.
// Backpressure: none on the data path; cfg_ready is low only during the single COMMIT cycle.
module mux_xbar_cfg #(
    parameter int N_IN  = 70,
    parameter int N_OUT = 128,
    parameter int W     = 196,
    parameter int SEL_W = $clog2(N_IN + 1),
    parameter int OA_W  = $clog2(N_OUT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [N_IN*W-1:0]    in_data,
    output logic                 out_valid,
    output logic [N_OUT*W-1:0]   out_data,
    output logic [N_IN-1:0]      in_uniform,
    output logic [N_OUT-1:0]     out_uniform,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [OA_W-1:0]      cfg_addr,
    input  logic [SEL_W-1:0]     cfg_sel,
    input  logic                 cfg_commit,
    output logic                 cfg_busy,
    output logic                 cfg_err
);

    // Routing value meaning "no source": the slot is driven to zero.
    localparam logic [SEL_W-1:0] SEL_NC = SEL_W'(N_IN);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } cfg_state_t;

    cfg_state_t         state;
    cfg_state_t         state_nxt;

    logic [SEL_W-1:0]   shadow  [N_OUT];
    logic [SEL_W-1:0]   active  [N_OUT];
    logic [SEL_W-1:0]   map_eff [N_OUT];

    logic               wr_en;
    logic               copy_en;
    logic               addr_ok;
    logic               sel_ok;
    logic [SEL_W-1:0]   wr_sel;

    logic               s1_valid;
    logic [N_IN*W-1:0]  s1_data;
    logic [N_IN-1:0]    s1_uniform;
    logic [N_OUT*W-1:0] mux_data;
    logic [N_OUT-1:0]   mux_uniform;

    // True when every bit of a channel/slot word has the same value.
    function automatic logic is_uniform(input logic [W-1:0] v);
        return (&v) | ~(|v);
    endfunction

    // Config FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Config FSM next state and handshake outputs; writes only land while idle.
    always_comb begin
        state_nxt = state;
        cfg_ready = 1'b0;
        cfg_busy  = 1'b0;
        wr_en     = 1'b0;
        copy_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                wr_en     = cfg_valid;
                if (cfg_commit) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                cfg_busy  = 1'b1;
                copy_en   = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Legality of the current write: out-of-range slots are dropped, out-of-range sources become unconnected.
    always_comb begin
        addr_ok = (int'(cfg_addr) < N_OUT);
        sel_ok  = (int'(cfg_sel) <= N_IN);
        wr_sel  = sel_ok ? cfg_sel : SEL_NC;
    end

    // Sticky error flag for any illegal write accepted in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_err <= 1'b0;
        end else if (wr_en && (!addr_ok || !sel_ok)) begin
            cfg_err <= 1'b1;
        end
    end

    // Shadow table: one entry written per accepted cfg_valid; persists across commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < N_OUT; j++) begin
                shadow[j] <= SEL_NC;
            end
        end else if (wr_en && addr_ok) begin
            shadow[cfg_addr] <= wr_sel;
        end
    end

    // Active table: whole-table copy from shadow at the COMMIT exit edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < N_OUT; j++) begin
                active[j] <= SEL_NC;
            end
        end else if (copy_en) begin
            for (int j = 0; j < N_OUT; j++) begin
                active[j] <= shadow[j];
            end
        end
    end

    // Map seen by the mux: on the copy edge the new table is already used, so the switch is atomic per sample.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            map_eff[j] = copy_en ? shadow[j] : active[j];
        end
    end

    // Stage 1: capture the input sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= in_data;
            end
        end
    end

    // Per-channel uniform flags of the stage-1 sample.
    always_comb begin
        s1_uniform = '0;
        for (int i = 0; i < N_IN; i++) begin
            s1_uniform[i] = is_uniform(s1_data[i*W +: W]);
        end
    end

    // Crossbar: each slot picks its source channel; unconnected or unmatched entries yield zero.
    always_comb begin
        mux_data = '0;
        for (int j = 0; j < N_OUT; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                if (map_eff[j] == SEL_W'(i)) begin
                    mux_data[j*W +: W] = s1_data[i*W +: W];
                end
            end
        end
    end

    // Per-slot uniform flags of the mux result.
    always_comb begin
        mux_uniform = '0;
        for (int j = 0; j < N_OUT; j++) begin
            mux_uniform[j] = is_uniform(mux_data[j*W +: W]);
        end
    end

    // Stage 2: register data and both flag vectors together; hold them when no sample arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            in_uniform  <= '0;
            out_uniform <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data    <= mux_data;
                in_uniform  <= s1_uniform;
                out_uniform <= mux_uniform;
            end
        end
    end

endmodule

// File: tb/tb_mux_xbar_cfg.sv
`timescale 1ns/1ps
module tb_mux_xbar_cfg;

    localparam int N_IN  = 4;
    localparam int N_OUT = 6;
    localparam int W     = 8;
    localparam int SEL_W = 3;
    localparam int OA_W  = 3;
    localparam logic [SEL_W-1:0] NC = 3'd4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic [N_IN*W-1:0]    in_data;
    logic                 out_valid;
    logic [N_OUT*W-1:0]   out_data;
    logic [N_IN-1:0]      in_uniform;
    logic [N_OUT-1:0]     out_uniform;
    logic                 cfg_valid;
    logic                 cfg_ready;
    logic [OA_W-1:0]      cfg_addr;
    logic [SEL_W-1:0]     cfg_sel;
    logic                 cfg_commit;
    logic                 cfg_busy;
    logic                 cfg_err;

    always #5 clk = ~clk;

    mux_xbar_cfg #(.N_IN(N_IN), .N_OUT(N_OUT), .W(W), .SEL_W(SEL_W), .OA_W(OA_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data),
        .in_uniform(in_uniform), .out_uniform(out_uniform),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_err(cfg_err)
    );

    typedef struct packed {
        logic [N_OUT*W-1:0] d;
        logic [N_IN-1:0]    iu;
        logic [N_OUT-1:0]   ou;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state
    logic [SEL_W-1:0] m_shadow [N_OUT];
    logic [SEL_W-1:0] m_active [N_OUT];
    bit               m_commit;
    bit               m_err;
    bit               v_prev;
    exp_t             m_last;

    function automatic bit uni8(input logic [W-1:0] v);
        return (v == 8'h00) || (v == 8'hFF);
    endfunction

    function automatic exp_t calc(input logic [N_IN*W-1:0] d, input logic [SEL_W-1:0] m [N_OUT]);
        exp_t e;
        logic [W-1:0] s;
        e = '0;
        for (int i = 0; i < N_IN; i++) e.iu[i] = uni8(d[i*W +: W]);
        for (int j = 0; j < N_OUT; j++) begin
            s = (int'(m[j]) < N_IN) ? d[int'(m[j])*W +: W] : 8'h00;
            e.d[j*W +: W] = s;
            e.ou[j] = uni8(s);
        end
        return e;
    endfunction

    function automatic logic [N_IN*W-1:0] rand_data();
        logic [N_IN*W-1:0] r;
        int pick;
        for (int i = 0; i < N_IN; i++) begin
            pick = $urandom_range(0, 3);
            r[i*W +: W] = (pick == 0) ? 8'h00 : (pick == 1) ? 8'hFF : W'($urandom);
        end
        return r;
    endfunction

    // One clock: drive inputs, predict, advance model at the edge, then check outputs 1ns later.
    task automatic step(input logic iv, input logic [N_IN*W-1:0] d, input logic cv,
                        input logic [OA_W-1:0] ca, input logic [SEL_W-1:0] cs, input logic cc);
        logic [SEL_W-1:0] eff [N_OUT];
        exp_t e;
        bit   exp_ov;
        in_valid = iv; in_data = d; cfg_valid = cv; cfg_addr = ca; cfg_sel = cs; cfg_commit = cc;
        if (iv) begin
            for (int j = 0; j < N_OUT; j++) eff[j] = m_active[j];
            if (m_commit) begin
                for (int j = 0; j < N_OUT; j++) eff[j] = m_shadow[j];
            end else if (cc) begin
                for (int j = 0; j < N_OUT; j++) eff[j] = m_shadow[j];
                if (cv && int'(ca) < N_OUT) eff[ca] = (int'(cs) > N_IN) ? NC : cs;
            end
            exp_q.push_back(calc(d, eff));
        end
        @(posedge clk);
        if (m_commit) begin
            for (int j = 0; j < N_OUT; j++) m_active[j] = m_shadow[j];
            m_commit = 0;
        end else begin
            if (cv) begin
                if (int'(ca) >= N_OUT) m_err = 1;
                else if (int'(cs) > N_IN) begin m_err = 1; m_shadow[ca] = NC; end
                else m_shadow[ca] = cs;
            end
            if (cc) m_commit = 1;
        end
        exp_ov = v_prev;
        v_prev = iv;
        #1;
        n_checks++;
        if (out_valid !== exp_ov) begin
            n_fail++; $display("FAIL out_valid: got %b expected %b", out_valid, exp_ov);
        end
        if (exp_ov) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++; $display("FAIL scoreboard: got output with queue size %0d expected >0", exp_q.size());
            end else begin
                e = exp_q.pop_front();
                m_last = e;
            end
        end
        n_checks++;
        if (out_data !== m_last.d) begin
            n_fail++; $display("FAIL out_data: got %h expected %h", out_data, m_last.d);
        end
        n_checks++;
        if (in_uniform !== m_last.iu) begin
            n_fail++; $display("FAIL in_uniform: got %b expected %b", in_uniform, m_last.iu);
        end
        n_checks++;
        if (out_uniform !== m_last.ou) begin
            n_fail++; $display("FAIL out_uniform: got %b expected %b", out_uniform, m_last.ou);
        end
        n_checks++;
        if (cfg_ready !== !m_commit || cfg_busy !== m_commit) begin
            n_fail++; $display("FAIL cfg_ready/busy: got %b/%b expected %b/%b", cfg_ready, cfg_busy, !m_commit, m_commit);
        end
        n_checks++;
        if (cfg_err !== m_err) begin
            n_fail++; $display("FAIL cfg_err: got %b expected %b", cfg_err, m_err);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [OA_W-1:0] ca, input logic [SEL_W-1:0] cs);
        step(1'b0, '0, 1'b1, ca, cs, 1'b0);
    endtask

    task automatic commit_and_wait();
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        idle(2);
    endtask

    task automatic do_reset();
        in_valid = 0; in_data = '0; cfg_valid = 0; cfg_addr = '0; cfg_sel = '0; cfg_commit = 0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int j = 0; j < N_OUT; j++) begin m_shadow[j] = NC; m_active[j] = NC; end
        m_commit = 0; m_err = 0; v_prev = 0; m_last = '0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            n_fail++; $display("FAIL reset_out: got valid=%b data=%h expected 0/0", out_valid, out_data);
        end
        n_checks++;
        if (in_uniform !== '0 || out_uniform !== '0) begin
            n_fail++; $display("FAIL reset_flags: got %b/%b expected 0/0", in_uniform, out_uniform);
        end
        n_checks++;
        if (cfg_ready !== 1'b1 || cfg_busy !== 1'b0 || cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_cfg: got rdy=%b busy=%b err=%b expected 1/0/0", cfg_ready, cfg_busy, cfg_err);
        end
    endtask

    task automatic test_unconnected_stream();
        for (int k = 0; k < 6; k++) step(1'b1, rand_data(), 1'b0, '0, '0, 1'b0);
        idle(2);
        n_checks++;
        if (out_data !== '0 || out_uniform !== 6'b111111) begin
            n_fail++; $display("FAIL unconnected: got data=%h ou=%b expected 0/111111", out_data, out_uniform);
        end
    endtask

    task automatic test_route();
        logic [N_IN*W-1:0] d;
        d = {8'h00, 8'hA5, 8'h3C, 8'hFF};
        wr(3'd0, 3'd2);
        wr(3'd5, 3'd0);
        commit_and_wait();
        step(1'b1, d, 1'b0, '0, '0, 1'b0);
        idle(2);
        n_checks++;
        if (out_data[0 +: 8] !== 8'hA5 || out_data[40 +: 8] !== 8'hFF || out_data[39:8] !== 32'h0) begin
            n_fail++; $display("FAIL route_data: got %h expected ff00000000a5", out_data);
        end
        n_checks++;
        if (in_uniform[0] !== 1'b1 || in_uniform[2] !== 1'b0) begin
            n_fail++; $display("FAIL route_iu: got %b expected x0x1", in_uniform);
        end
        n_checks++;
        if (out_uniform[5] !== 1'b1 || out_uniform[0] !== 1'b0) begin
            n_fail++; $display("FAIL route_ou: got %b expected 1xxxx0", out_uniform);
        end
    endtask

    task automatic test_commit_midstream();
        int low_cnt;
        low_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b1, rand_data(), (k < 2), (k == 0) ? 3'd1 : 3'd3, (k == 0) ? 3'd1 : 3'd3, (k == 4));
            if (!cfg_ready) low_cnt++;
        end
        idle(2);
        n_checks++;
        if (low_cnt !== 1) begin
            n_fail++; $display("FAIL ready_low_cycles: got %0d expected 1", low_cnt);
        end
    endtask

    task automatic test_same_cycle();
        logic [N_IN*W-1:0] d;
        wr(3'd1, 3'd0);
        commit_and_wait();
        step(1'b1, rand_data(), 1'b1, 3'd1, 3'd3, 1'b1);
        step(1'b1, rand_data(), 1'b1, 3'd2, 3'd1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, rand_data(), 1'b0, '0, '0, 1'b0);
        idle(2);
        commit_and_wait();
        d = {8'hC3, 8'h11, 8'h5A, 8'h22};
        step(1'b1, d, 1'b0, '0, '0, 1'b0);
        idle(2);
        n_checks++;
        if (out_data[8 +: 8] !== 8'hC3) begin
            n_fail++; $display("FAIL same_cycle_slot1: got %h expected c3", out_data[8 +: 8]);
        end
        n_checks++;
        if (out_data[16 +: 8] !== 8'h00) begin
            n_fail++; $display("FAIL commit_ignored_slot2: got %h expected 00", out_data[16 +: 8]);
        end
    endtask

    task automatic test_illegal();
        logic [N_IN*W-1:0] d;
        wr(3'd4, 3'd1);
        commit_and_wait();
        wr(3'd6, 3'd1);
        n_checks++;
        if (cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL err_addr: got %b expected 1", cfg_err);
        end
        wr(3'd4, 3'd7);
        commit_and_wait();
        d = {8'h77, 8'h66, 8'h99, 8'h44};
        step(1'b1, d, 1'b0, '0, '0, 1'b0);
        idle(3);
        n_checks++;
        if (out_data[32 +: 8] !== 8'h00 || cfg_err !== 1'b1) begin
            n_fail++; $display("FAIL illegal_sel: got slot4=%h err=%b expected 00/1", out_data[32 +: 8], cfg_err);
        end
    endtask

    task automatic test_rst_mid_commit();
        step(1'b1, {8'h12, 8'h34, 8'h56, 8'h78}, 1'b0, '0, '0, 1'b0);
        idle(2);
        wr(3'd2, 3'd1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        n_checks++;
        if (cfg_busy !== 1'b1) begin
            n_fail++; $display("FAIL pre_rst_busy: got %b expected 1", cfg_busy);
        end
        do_reset();
        n_checks++;
        if (out_data !== '0 || out_valid !== 1'b0 || in_uniform !== '0 || out_uniform !== '0) begin
            n_fail++; $display("FAIL rst_mid_out: got data=%h valid=%b expected 0", out_data, out_valid);
        end
        n_checks++;
        if (cfg_busy !== 1'b0 || cfg_ready !== 1'b1 || cfg_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_cfg: got busy=%b rdy=%b err=%b expected 0/1/0", cfg_busy, cfg_ready, cfg_err);
        end
        idle(2);
        step(1'b1, {8'hAB, 8'hCD, 8'hEF, 8'h12}, 1'b0, '0, '0, 1'b0);
        idle(2);
        n_checks++;
        if (out_data !== '0 || out_uniform !== 6'b111111) begin
            n_fail++; $display("FAIL rst_mid_route: got data=%h ou=%b expected 0/111111", out_data, out_uniform);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_unconnected_stream();
        test_route();
        test_commit_midstream();
        test_same_cycle();
        test_illegal();
        test_rst_mid_commit();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
